// File: rtl/sccb_master_write.sv
// Write-only SCCB master: turns one (sub-address, data) request into a
// three-phase write (device ID, sub-address, data) on sio_c/sio_d.
module sccb_master_write #(
  parameter int          CLK_DIV    = 500,
  parameter logic [7:0]  DEVICE_ID  = 8'h42,
  parameter int          INIT_DELAY = 1000000
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       write_en,
  input  logic [7:0] sccb_addr,
  input  logic [7:0] sccb_data,
  output logic       data_finish,
  output logic       init_en,
  output logic       sio_c,
  inout  wire        sio_d
);

  localparam int Q  = CLK_DIV / 4;
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;
  localparam int CW = $clog2(INIT_DELAY + 1);
  // The ninth slot of every byte is released so the sensor may drive ACK.
  localparam logic [26:0] XMASK = 27'b000000001_000000001_000000001;

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_e;

  state_e         state_q, state_d;
  logic [QW-1:0]  cyc_q, cyc_d;
  logic [1:0]     qtr_q, qtr_d;
  logic [4:0]     bit_q, bit_d;
  logic [26:0]    frame_q, frame_d;
  logic [26:0]    xmask_q, xmask_d;
  logic [CW-1:0]  init_cnt_q, init_cnt_d;
  logic           init_en_q, init_en_d;
  logic           data_finish_q, data_finish_d;
  logic           sio_c_q, sio_c_d;
  logic           sio_do_q, sio_do_d;
  logic           sio_oe_q, sio_oe_d;
  logic           qlast;

  assign qlast = (cyc_q == QW'(Q - 1));

  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    qtr_d         = qtr_q;
    bit_d         = bit_q;
    frame_d       = frame_q;
    xmask_d       = xmask_q;
    init_cnt_d    = init_cnt_q;
    init_en_d     = init_en_q;
    data_finish_d = 1'b0;
    sio_c_d       = sio_c_q;
    sio_do_d      = sio_do_q;
    sio_oe_d      = sio_oe_q;

    if (!init_en_q) begin
      init_cnt_d = init_cnt_q + CW'(1);
      if (init_cnt_d == CW'(INIT_DELAY)) init_en_d = 1'b1;
    end

    if (state_q != IDLE) cyc_d = qlast ? '0 : cyc_q + QW'(1);

    // Outputs are set on the edge that enters each quarter, so sio_d only
    // moves together with a falling sio_c inside the data phase.
    case (state_q)
      IDLE: begin
        sio_c_d  = 1'b1;
        sio_do_d = 1'b1;
        sio_oe_d = 1'b1;
        if (init_en_q && write_en) begin
          state_d = START;
          cyc_d   = '0;
          qtr_d   = 2'd0;
          frame_d = {DEVICE_ID, 1'b1, sccb_addr, 1'b1, sccb_data, 1'b1};
          xmask_d = XMASK;
        end
      end
      START: if (qlast) begin
        if (qtr_q == 2'd0) begin
          qtr_d    = 2'd1;
          sio_do_d = 1'b0;
        end else begin
          state_d  = SHIFT;
          qtr_d    = 2'd0;
          bit_d    = 5'd0;
          sio_c_d  = 1'b0;
          sio_do_d = frame_q[26];
          sio_oe_d = ~xmask_q[26];
        end
      end
      SHIFT: if (qlast) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd1) sio_c_d = 1'b1;
        if (qtr_q == 2'd3) begin
          sio_c_d = 1'b0;
          if (bit_q == 5'd26) begin
            state_d  = STOP;
            qtr_d    = 2'd0;
            sio_do_d = 1'b0;
            sio_oe_d = 1'b1;
          end else begin
            bit_d    = bit_q + 5'd1;
            frame_d  = frame_q << 1;
            xmask_d  = xmask_q << 1;
            sio_do_d = frame_q[25];
            sio_oe_d = ~xmask_q[25];
          end
        end
      end
      STOP: if (qlast) begin
        qtr_d = qtr_q + 2'd1;
        case (qtr_q)
          2'd0:    sio_c_d = 1'b1;
          2'd1:    sio_do_d = 1'b1;
          default: begin
            state_d       = IDLE;
            qtr_d         = 2'd0;
            data_finish_d = 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst_n) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      qtr_q         <= '0;
      bit_q         <= '0;
      frame_q       <= '0;
      xmask_q       <= '0;
      init_cnt_q    <= '0;
      init_en_q     <= 1'b0;
      data_finish_q <= 1'b0;
      sio_c_q       <= 1'b1;
      sio_do_q      <= 1'b1;
      sio_oe_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      qtr_q         <= qtr_d;
      bit_q         <= bit_d;
      frame_q       <= frame_d;
      xmask_q       <= xmask_d;
      init_cnt_q    <= init_cnt_d;
      init_en_q     <= init_en_d;
      data_finish_q <= data_finish_d;
      sio_c_q       <= sio_c_d;
      sio_do_q      <= sio_do_d;
      sio_oe_q      <= sio_oe_d;
    end
  end

  assign init_en     = init_en_q;
  assign data_finish = data_finish_q;
  assign sio_c       = sio_c_q;
  assign sio_d       = sio_oe_q ? sio_do_q : 1'bz;

endmodule

// File: tb/tb_sccb_master_write.sv
// Directed bench for sccb_master_write: power-up delay, single write,
// reset abort, and back-to-back writes, with a slave that pulls ACK low.
module tb_sccb_master_write;
  localparam int CLK_DIV    = 8;
  localparam int INIT_DELAY = 20;
  localparam int WIN        = 227;  // START entry sample .. data_finish sample

  logic       sclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       write_en = 1'b0;
  logic [7:0] sccb_addr = 8'h00;
  logic [7:0] sccb_data = 8'h00;
  logic       data_finish, init_en, sio_c;
  logic       ack_drv = 1'b0;
  tri         sio_d;

  int errors = 0;
  int checks = 0;

  pullup (sio_d);
  assign sio_d = ack_drv ? 1'b0 : 1'bz;

  sccb_master_write #(.CLK_DIV(CLK_DIV), .DEVICE_ID(8'h42), .INIT_DELAY(INIT_DELAY)) dut (
    .sclk(sclk), .rst_n(rst_n), .write_en(write_en), .sccb_addr(sccb_addr),
    .sccb_data(sccb_data), .data_finish(data_finish), .init_en(init_en),
    .sio_c(sio_c), .sio_d(sio_d)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a negedge while reset is held; releases it and follows init_en.
  task automatic do_init(input string tag);
    int bad;
    bad = 0;
    rst_n = 1'b0;
    for (int i = 1; i < INIT_DELAY; i++) begin
      @(negedge sclk);
      if (init_en !== 1'b0 || sio_c !== 1'b1 || sio_d !== 1'b1 || data_finish !== 1'b0) bad++;
    end
    chk({tag, "_quiet_before_init"}, bad, 0);
    @(negedge sclk);
    chk({tag, "_init_en_rise"}, init_en, 1'b1);
    chk({tag, "_idle_sio_c"}, sio_c, 1'b1);
  endtask

  // Samples one transfer; the first posedge after the call must be START entry.
  task automatic capture(input bit scramble, output logic [7:0] b0, output logic [7:0] b1,
                         output logic [7:0] b2, output logic [2:0] xs, output int rises,
                         output int fin_cyc, output int pulses, output int hi_chg);
    logic [26:0] bits;
    logic pc, pd;
    bits = '0; pc = sio_c; pd = sio_d;
    rises = 0; fin_cyc = -1; pulses = 0; hi_chg = 0;
    for (int cyc = 1; cyc <= WIN; cyc++) begin
      @(negedge sclk);
      if (scramble && cyc == 10) begin
        sccb_addr = 8'hFF;
        sccb_data = 8'hFF;
      end
      if (pc === 1'b1 && sio_c === 1'b1 && sio_d !== pd) hi_chg++;
      if (pc === 1'b0 && sio_c === 1'b1) begin
        if (rises < 27) bits[26 - rises] = sio_d;
        rises++;
      end
      if (pc === 1'b1 && sio_c === 1'b0) begin
        if (ack_drv) ack_drv = 1'b0;
        else if (rises == 8 || rises == 17 || rises == 26) ack_drv = 1'b1;
      end
      if (data_finish === 1'b1) begin
        pulses++;
        if (fin_cyc < 0) fin_cyc = cyc;
      end
      pc = sio_c; pd = sio_d;
    end
    ack_drv = 1'b0;
    b0 = bits[26:19]; xs[2] = bits[18];
    b1 = bits[17:10]; xs[1] = bits[9];
    b2 = bits[8:1];   xs[0] = bits[0];
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] ea, input logic [7:0] ed,
                            input bit scramble);
    logic [7:0] b0, b1, b2;
    logic [2:0] xs;
    int rises, fin_cyc, pulses, hi_chg;
    capture(scramble, b0, b1, b2, xs, rises, fin_cyc, pulses, hi_chg);
    chk({tag, "_id"}, b0, 8'h42);
    chk({tag, "_addr"}, b1, ea);
    chk({tag, "_data"}, b2, ed);
    chk({tag, "_ack_slots"}, xs, 3'b000);
    chk({tag, "_sio_c_rises"}, rises, 28);
    chk({tag, "_finish_cycle"}, fin_cyc, WIN);
    chk({tag, "_finish_pulses"}, pulses, 1);
    chk({tag, "_sio_d_moves_while_c_high"}, hi_chg, 2);
  endtask

  initial begin
    int bad;
    repeat (2) @(negedge sclk);
    chk("reset_sio_c", sio_c, 1'b1);
    chk("reset_sio_d", sio_d, 1'b1);
    chk("reset_init_en", init_en, 1'b0);
    chk("reset_finish", data_finish, 1'b0);

    // Request raised before the sensor is ready.
    sccb_addr = 8'h0C; sccb_data = 8'h0B; write_en = 1'b1;
    do_init("init1");
    check_xfer("wr1", 8'h0C, 8'h0B, 1'b1);
    write_en = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge sclk);
      if (sio_c !== 1'b1 || data_finish !== 1'b0) bad++;
    end
    chk("idle_after_wr1", bad, 0);

    // Abort in the middle of the sub-address byte.
    sccb_addr = 8'h55; sccb_data = 8'hAA; write_en = 1'b1;
    bad = 0;
    repeat (80) begin
      @(negedge sclk);
      if (data_finish !== 1'b0) bad++;
    end
    chk("no_finish_before_abort", bad, 0);
    rst_n = 1'b1; write_en = 1'b0;
    @(negedge sclk);
    chk("abort_sio_c", sio_c, 1'b1);
    chk("abort_sio_d", sio_d, 1'b1);
    chk("abort_init_en", init_en, 1'b0);
    chk("abort_finish", data_finish, 1'b0);
    @(negedge sclk);

    // Re-init, then two writes back to back with write_en held.
    sccb_addr = 8'h3A; sccb_data = 8'h5C; write_en = 1'b1;
    do_init("init2");
    check_xfer("wr2", 8'h3A, 8'h5C, 1'b0);
    sccb_addr = 8'h12; sccb_data = 8'h80;
    check_xfer("wr3", 8'h12, 8'h80, 1'b0);
    write_en = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge sclk);
      if (sio_c !== 1'b1 || data_finish !== 1'b0) bad++;
    end
    chk("idle_after_b2b", bad, 0);
    chk("init_en_held", init_en, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_master_write.md
Name: sccb_master_write

Overview:
- Write-only SCCB (I2C-like) master for OV7670 camera register configuration.
- Converts a single write request (register address + data) into a 3-phase SCCB write on sio_c/sio_d: device ID, sub-address, data.
- Sits between the camera init-sequence ROM/controller and the sensor pins.
- Signals power-up readiness (init_en) and completion of each write (data_finish).

Parameters:
- CLK_DIV, 500: sclk cycles per sio_c period (50 MHz -> 100 kHz). Must be a multiple of 4 and >= 4. Q = CLK_DIV/4 is one quarter-period.
- DEVICE_ID, 8'h42: SCCB write ID of the sensor, sent as phase 1.
- INIT_DELAY, 1000000: sclk cycles after reset release before init_en rises (sensor power-up wait).

Ports:
- sclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-high reset (high = reset, despite the _n suffix).
- write_en  in  1  level request to start a write.
- sccb_addr  in  8  register sub-address.
- sccb_data  in  8  register data.
- data_finish  out  1  one-cycle pulse when a write has fully completed.
- init_en  out  1  high once the power-up delay has elapsed; stays high until reset.
- sio_c  out  1  SCCB clock.
- sio_d  inout  1  SCCB data; driven 0/1 or high-Z.

Behaviour:
- Reset values:
  - init_en=0, data_finish=0, sio_c=1, sio_d driven 1.
  - State IDLE; all counters 0.
- Reset asserted at any time, including mid-transfer, aborts immediately to the reset values. There is no partial stop condition.
- init_en:
  - A counter runs from reset release.
  - init_en goes 1 on the cycle the counter reaches INIT_DELAY, then holds.
- Request acceptance:
  - In IDLE, with init_en=1 and write_en=1 sampled on a clock edge, latch sccb_addr/sccb_data and enter START.
  - write_en while init_en=0 is ignored.
  - Input changes after latching are ignored.
- States: IDLE -> START -> SHIFT -> STOP -> IDLE.
- START (2Q cycles):
  - sio_c=1.
  - sio_d=1 for Q cycles, then 0 for Q cycles.
- SHIFT: 27 bit slots of 4Q cycles each.
  - Bit sequence: DEVICE_ID[7:0], X, addr[7:0], X, data[7:0], X. All bytes MSB first.
  - Q0 and Q1 of each slot: sio_c=0. Q2 and Q3: sio_c=1.
  - sio_d updates only at the start of Q0, i.e. only while sio_c is low.
  - X (9th, don't-care) slots: sio_d is high-Z for the whole slot. The ACK is not checked.
- STOP (3Q cycles):
  - Q cycles: sio_c=0, sio_d=0.
  - Q cycles: sio_c=1, sio_d=0.
  - Q cycles: sio_c=1, sio_d=1.
- Completion:
  - On leaving STOP, data_finish=1 for exactly one cycle and the state returns to IDLE.
  - Total transfer = 113Q cycles from START entry to data_finish.
- Back-to-back: if write_en is still 1 in the IDLE cycle after data_finish, a new transfer starts on the next edge with freshly latched inputs. Hold write_en low to stop.
- In IDLE, sio_c=1 and sio_d driven 1.

Test Plan:
- Reset/init: CLK_DIV=8, INIT_DELAY=20; hold rst_n=1 for 2 cycles, then release -> sio_c=1, sio_d=1, init_en=0 for 20 cycles, then init_en=1 permanently, data_finish=0.
- Early request: write_en=1 before init_en=1 -> no sio_c toggling until init_en rises; transfer starts on the first edge with init_en=1.
- Single write, addr=8'h0C, data=8'h0B:
  - Start condition: sio_d falls while sio_c=1.
  - Bits sampled on each sio_c rise read 0x42, Z, 0x0C, Z, 0x0B, Z.
  - Stop condition: sio_d rises while sio_c=1.
  - data_finish pulses once, exactly 226 cycles (113*2) after START entry.
- Bit-change rule: across the whole transfer, check sio_d never changes while sio_c=1, except at the start and stop edges.
- Reset mid-transfer: assert rst_n during the address byte -> next cycle sio_c=1, sio_d=1, init_en=0, no data_finish; after re-init a full transfer completes correctly.
- Back-to-back: hold write_en=1 and change addr to 8'h12, data to 8'h80 after the first data_finish -> second transfer carries 0x42, 0x12, 0x80; two data_finish pulses total.
